load_unit_mp: RTL and testbench

- Parametrised load functional unit for the superscalar dispatch path.
- Snoops NUM_BUS 40-bit instruction buses and claims LOAD instructions tagged to its NUM_TAGS reservation-station tags.
- Buffers claimed loads in a DEPTH-entry in-order queue and issues them one at a time to memory over a valid/ready request and a valid response.
- Returns {dest_reg, data} on a valid/ready writeback port; adds multi-bus capture, queuing, backpressure, stall and overflow reporting.

---
 rtl/load_pkg.sv | 41 ++++
 rtl/ld_queue.sv | 66 ++++++
 rtl/load_unit_mp.sv | 100 ++++++++++
 tb/tb_load_unit_mp.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared field layout, opcode/tag/register constants and FSM encoding for the load unit.
package load_pkg;

  localparam int BUS_W   = 40;
  localparam int TAG_HI  = 39;
  localparam int TAG_LO  = 32;
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 24;
  localparam int ADDR_HI = 23;
  localparam int ADDR_LO = 8;
  localparam int DST_HI  = 7;
  localparam int DST_LO  = 0;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_MULTI = 8'h04;

  localparam logic [7:0] TAG_LD0 = 8'h40;
  localparam logic [7:0] TAG_LD1 = 8'h41;
  localparam logic [7:0] TAG_ST0 = 8'h50;
  localparam logic [7:0] TAG_ST1 = 8'h51;
  localparam logic [7:0] TAG_A0  = 8'h20;
  localparam logic [7:0] TAG_A1  = 8'h21;
  localparam logic [7:0] TAG_A2  = 8'h22;
  localparam logic [7:0] TAG_M0  = 8'h30;
  localparam logic [7:0] TAG_M1  = 8'h31;

  localparam logic [7:0] REG_R0 = 8'h10;
  localparam logic [7:0] REG_R1 = 8'h11;
  localparam logic [7:0] REG_R2 = 8'h12;
  localparam logic [7:0] REG_R3 = 8'h13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/ld_queue.sv
// In-order FIFO: up to NUM_BUS pushes (lowest index first) and one pop per cycle.
// free reports space after this cycle's update, so a pop makes room for a same-cycle push.
module ld_queue #(
  parameter int DEPTH   = 4,
  parameter int NUM_BUS = 2,
  parameter int W       = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_BUS-1:0]            push,
  input  logic [NUM_BUS-1:0][W-1:0]     push_dat,
  input  logic                          pop,
  output logic [NUM_BUS-1:0]            accept,
  output logic [W-1:0]                  head_dat,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [$clog2(DEPTH+1)-1:0]    free
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] slot [NUM_BUS];
  logic [CW-1:0] avail, n_push, count_nxt;
  logic          pop_ok;

  always_comb begin
    pop_ok = pop && (count != '0);
    avail  = CW'(DEPTH) - count + CW'(pop_ok);
    n_push = '0;
    accept = '0;
    for (int i = 0; i < NUM_BUS; i++) begin
      slot[i] = '0;
      if (push[i] && (n_push < avail)) begin
        accept[i] = 1'b1;
        slot[i]   = wr_ptr + PW'(n_push);
        n_push    = n_push + 1'b1;
      end
    end
    count_nxt = count + n_push - CW'(pop_ok);
    free      = CW'(DEPTH) - count_nxt;
  end

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(pop_ok);
      count  <= count_nxt;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BUS; i++) begin
      if (accept[i]) mem[slot[i]] <= push_dat[i];
    end
  end

endmodule

// File: rtl/load_unit_mp.sv
// Snoops NUM_BUS instruction buses, queues claimed loads and serves them one at a time.
// Request appears 2 cycles after capture; writeback stalls the queue head until loadout_ready.
module load_unit_mp
  import load_pkg::*;
#(
  parameter int         NUM_BUS  = 2,
  parameter int         DEPTH    = 4,
  parameter int         NUM_TAGS = 2,
  parameter logic [7:0] TAG_BASE = TAG_LD0,
  parameter logic [7:0] LOAD_OP  = OP_LOAD,
  parameter int         ADDR_W   = 16,
  parameter int         DATA_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_BUS*40-1:0]   instbus,
  output logic                    ld_stall,
  output logic                    ld_overflow,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-1:0]       mem_req_addr,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_W-1:0]       mem_rsp_data,
  output logic                    loadout_valid,
  input  logic                    loadout_ready,
  output logic [8+DATA_W-1:0]     loadout
);

  localparam int EW = 8 + ADDR_W;
  localparam int CW = $clog2(DEPTH+1);

  ld_state_e                     state, state_nxt;
  logic [NUM_BUS-1:0]            hit, accept;
  logic [NUM_BUS-1:0][EW-1:0]    ent;
  logic [EW-1:0]                 head;
  logic [CW-1:0]                 count, free;
  logic [DATA_W-1:0]             rsp_q;
  logic                          pop;

  always_comb begin
    for (int i = 0; i < NUM_BUS; i++) begin
      logic [8:0] tag9;
      tag9   = {1'b0, instbus[BUS_W*i + TAG_LO +: 8]};
      hit[i] = (tag9 >= {1'b0, TAG_BASE}) &&
               (tag9 < ({1'b0, TAG_BASE} + 9'(NUM_TAGS))) &&
               (instbus[BUS_W*i + OP_LO +: 8] == LOAD_OP);
      ent[i] = {instbus[BUS_W*i + DST_LO +: 8], instbus[BUS_W*i + ADDR_LO +: ADDR_W]};
    end
  end

  assign pop = (state == ST_OUT) && loadout_ready;

  ld_queue #(
    .DEPTH   (DEPTH),
    .NUM_BUS (NUM_BUS),
    .W       (EW)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (hit),
    .push_dat (ent),
    .pop      (pop),
    .accept   (accept),
    .head_dat (head),
    .count    (count),
    .free     (free)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (count != '0) state_nxt = ST_REQ;
      ST_REQ:  if (mem_req_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (mem_rsp_valid) state_nxt = ST_OUT;
      ST_OUT:  if (loadout_ready) state_nxt = (free != CW'(DEPTH)) ? ST_REQ : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rsp_q       <= '0;
      ld_stall    <= 1'b0;
      ld_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      ld_stall    <= free < CW'(NUM_BUS);
      ld_overflow <= ld_overflow | (|(hit & ~accept));
      if ((state == ST_WAIT) && mem_rsp_valid) rsp_q <= mem_rsp_data;
    end
  end

  // Head entry is stable until popped, so gating by state keeps outputs steady and zero at reset.
  assign mem_req_valid = (state == ST_REQ);
  assign mem_req_addr  = (state == ST_REQ) ? head[ADDR_W-1:0] : '0;
  assign loadout_valid = (state == ST_OUT);
  assign loadout       = (state == ST_OUT) ? {head[EW-1 -: 8], rsp_q} : '0;

endmodule

// File: tb/tb_load_unit_mp.sv
// Directed bench for load_unit_mp: vector table for capture/filtering plus hand sequences.
module tb_load_unit_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [79:0] instbus = '0;
  logic        ld_stall, ld_overflow, mem_req_valid, loadout_valid;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0, loadout_ready = 1'b0;
  logic [15:0] mem_req_addr;
  logic [31:0] mem_rsp_data = '0;
  logic [39:0] loadout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_unit_mp dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instbus       (instbus),
    .ld_stall      (ld_stall),
    .ld_overflow   (ld_overflow),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .loadout_valid (loadout_valid),
    .loadout_ready (loadout_ready),
    .loadout       (loadout)
  );

  typedef struct {
    logic [39:0] b0;
    logic [39:0] b1;
    logic        rq_rdy;
    logic        rsp_vld;
    logic [31:0] rsp_dat;
    logic        lo_rdy;
    logic        stall;
    logic        ovf;
    logic        mrv;
    logic [15:0] addr;
    logic        lv;
    logic [39:0] lo;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {4'h0, ld_stall, ld_overflow, mem_req_valid, mem_req_addr, loadout_valid, loadout};
  endfunction

  // Enter in REQ with mem_req_ready=1; completes one load and pops it.
  task automatic serve(input logic [15:0] a, input logic [31:0] d, input logic [7:0] dst);
    chk("serve_req", {mem_req_valid, mem_req_addr}, {1'b1, a});
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    step();
    mem_rsp_valid = 1'b0;
    chk("serve_out", {loadout_valid, loadout}, {1'b1, dst, d});
    loadout_ready = 1'b1;
    step();
    loadout_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{40'h40_01_0000_10, 40'h41_01_0000_12, 1, 0, 32'h0, 1, 0, 0, 0, 16'h0, 0, 40'h0};
    vecs[1] = '{40'h0, 40'h0, 1, 0, 32'h0, 1, 0, 0, 1, 16'h0000, 0, 40'h0};
    vecs[2] = '{40'h0, 40'h0, 1, 0, 32'h0, 1, 0, 0, 0, 16'h0, 0, 40'h0};
    vecs[3] = '{40'h0, 40'h0, 1, 1, 32'h47bdce12, 1, 0, 0, 0, 16'h0, 1, 40'h10_47bdce12};
    vecs[4] = '{40'h0, 40'h0, 1, 0, 32'h0, 1, 0, 0, 1, 16'h0000, 0, 40'h0};
    vecs[5] = '{40'h0, 40'h0, 1, 0, 32'h0, 1, 0, 0, 0, 16'h0, 0, 40'h0};
    vecs[6] = '{40'h0, 40'h0, 1, 1, 32'h345612bc, 1, 0, 0, 0, 16'h0, 1, 40'h12_345612bc};
    vecs[7] = '{40'h0, 40'h0, 1, 0, 32'h0, 1, 0, 0, 0, 16'h0, 0, 40'h0};
    vecs[8] = '{40'h50_02_0010_11, 40'h20_03_0000_13, 1, 0, 32'h0, 1, 0, 0, 0, 16'h0, 0, 40'h0};
    vecs[9] = '{40'h0, 40'h0, 1, 0, 32'h0, 1, 0, 0, 0, 16'h0, 0, 40'h0};

    // Reset state
    #12;
    chk("reset_outs", outs(), 64'h0);
    step();
    rst_n = 1'b1;

    // Dual capture and opcode/tag filtering
    for (int i = 0; i < 10; i++) begin
      instbus       = {vecs[i].b1, vecs[i].b0};
      mem_req_ready = vecs[i].rq_rdy;
      mem_rsp_valid = vecs[i].rsp_vld;
      mem_rsp_data  = vecs[i].rsp_dat;
      loadout_ready = vecs[i].lo_rdy;
      step();
      chk($sformatf("vec%0d", i), outs(),
          {4'h0, vecs[i].stall, vecs[i].ovf, vecs[i].mrv, vecs[i].addr, vecs[i].lv, vecs[i].lo});
    end
    instbus = '0;
    mem_rsp_valid = 1'b0;
    loadout_ready = 1'b0;

    // Writeback backpressure
    instbus = {40'h41_01_0030_13, 40'h40_01_0020_11};
    mem_req_ready = 1'b1;
    step();
    instbus = '0;
    step();
    chk("bp_req", {mem_req_valid, mem_req_addr}, {1'b1, 16'h0020});
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'ha5a50001;
    step();
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d", k), {loadout_valid, loadout, mem_req_valid},
          {1'b1, 40'h11_a5a50001, 1'b0});
      step();
    end
    loadout_ready = 1'b1;
    step();
    loadout_ready = 1'b0;
    chk("bp_release", {mem_req_valid, mem_req_addr, loadout_valid}, {1'b1, 16'h0030, 1'b0});
    serve(16'h0030, 32'h5a5a0002, 8'h13);
    chk("bp_idle", {mem_req_valid, loadout_valid}, 64'h0);

    // Memory request wait with a stray response
    mem_req_ready = 1'b0;
    instbus = {40'h0, 40'h40_01_1234_10};
    step();
    instbus = '0;
    step();
    chk("mw_req", {mem_req_valid, mem_req_addr}, {1'b1, 16'h1234});
    for (int k = 0; k < 3; k++) begin
      mem_rsp_valid = (k == 1);
      mem_rsp_data  = 32'hdeadbeef;
      step();
      mem_rsp_valid = 1'b0;
      chk($sformatf("mw_hold%0d", k), {mem_req_valid, mem_req_addr, loadout_valid},
          {1'b1, 16'h1234, 1'b0});
    end
    mem_req_ready = 1'b1;
    step();
    chk("mw_wait", {mem_req_valid, loadout_valid}, 64'h0);
    step();
    chk("mw_still_wait", {mem_req_valid, loadout_valid}, 64'h0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0badf00d;
    step();
    mem_rsp_valid = 1'b0;
    chk("mw_out", {loadout_valid, loadout}, {1'b1, 40'h10_0badf00d});
    loadout_ready = 1'b1;
    step();
    loadout_ready = 1'b0;
    chk("mw_idle", {mem_req_valid, loadout_valid}, 64'h0);

    // Overflow: fill 3, then two hits with one slot left
    mem_req_ready = 1'b0;
    instbus = {40'h41_01_0200_11, 40'h40_01_0100_10};
    step();
    chk("ov_fill2", {ld_stall, ld_overflow}, 64'h0);
    instbus = {40'h0, 40'h40_01_0300_12};
    step();
    chk("ov_fill3", {ld_stall, ld_overflow}, 64'h2);
    instbus = {40'h40_01_0500_10, 40'h41_01_0400_13};
    step();
    chk("ov_drop", {ld_stall, ld_overflow}, 64'h3);
    instbus = '0;
    step();
    chk("ov_sticky", {ld_overflow, mem_req_valid, mem_req_addr}, {1'b1, 1'b1, 16'h0100});
    mem_req_ready = 1'b1;
    serve(16'h0100, 32'h00000001, 8'h10);
    chk("ov_stall3", ld_stall, 64'h1);
    serve(16'h0200, 32'h00000002, 8'h11);
    chk("ov_stall2", ld_stall, 64'h0);
    serve(16'h0300, 32'h00000003, 8'h12);
    serve(16'h0400, 32'h00000004, 8'h13);
    step();
    chk("ov_dropped_gone", {mem_req_valid, loadout_valid, ld_overflow}, 64'h1);

    // Reset while waiting on memory
    instbus = {40'h0, 40'h40_01_0777_12};
    step();
    instbus = '0;
    step();
    chk("rs_req", {mem_req_valid, mem_req_addr}, {1'b1, 16'h0777});
    step();
    rst_n = 1'b0;
    #1;
    chk("rs_async", outs(), 64'h0);
    step();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h11112222;
    step();
    mem_rsp_valid = 1'b0;
    chk("rs_late_rsp", outs(), 64'h0);
    step();
    chk("rs_empty", outs(), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
